// File: rtl/timer_controller.sv
// timer_controller: keypad entry, seconds normalisation and BCD M:ST:SO countdown FSM
module timer_controller #(
   parameter int TICK_DIV = 100_000_000
) (
   input  logic       clock,
   input  logic       clear,
   input  logic       key_valid,
   input  logic [3:0] key_digit,
   input  logic       start,
   input  logic       stop,
   input  logic       door_closed,
   output logic [3:0] min,
   output logic [3:0] sec_tens,
   output logic [3:0] sec_ones,
   output logic       running,
   output logic       done,
   output logic [2:0] state
);
   localparam int PW = $clog2(TICK_DIV);
   typedef enum logic [2:0] {IDLE = 3'd0, ENTRY = 3'd1, RUN = 3'd2, PAUSE = 3'd3, DONE = 3'd4} state_t;
   state_t st, n_st;
   logic [PW-1:0] pre, n_pre;
   logic [3:0] n_min, n_tens, n_ones;
   logic [3:0] inc_min, norm_min, norm_tens, norm_ones, dec_min, dec_tens, dec_ones;
   logic kv, tick, zero, dec_zero, clamp;
   assign kv = key_valid && key_digit <= 4'd9;
   assign tick = pre == PW'(TICK_DIV - 1);
   assign zero = {min, sec_tens, sec_ones} == 12'd0;
   // seconds-tens above 5 carry into minutes; a carry out of 9 minutes saturates at 9:59
   assign inc_min = (sec_tens > 4'd5) ? min + 4'd1 : min;
   assign clamp = inc_min == 4'd10;
   assign norm_min = clamp ? 4'd9 : inc_min;
   assign norm_tens = clamp ? 4'd5 : (sec_tens > 4'd5 ? sec_tens - 4'd6 : sec_tens);
   assign norm_ones = clamp ? 4'd9 : sec_ones;
   assign dec_ones = (sec_ones == 4'd0) ? 4'd9 : sec_ones - 4'd1;
   assign dec_tens = (sec_ones != 4'd0) ? sec_tens : (sec_tens == 4'd0 ? 4'd5 : sec_tens - 4'd1);
   assign dec_min = (sec_ones == 4'd0 && sec_tens == 4'd0) ? min - 4'd1 : min;
   assign dec_zero = {dec_min, dec_tens, dec_ones} == 12'd0;
   always_comb begin
      n_st = st;
      n_min = min;
      n_tens = sec_tens;
      n_ones = sec_ones;
      n_pre = '0;
      case (st)
         IDLE, ENTRY, DONE: begin
            if (stop) begin
               n_st = IDLE;
               {n_min, n_tens, n_ones} = 12'd0;
            end else if (door_closed) begin
               if (start && st == ENTRY && !zero) begin
                  n_st = RUN;
                  {n_min, n_tens, n_ones} = {norm_min, norm_tens, norm_ones};
               end else if (start && st == DONE) begin
                  n_st = IDLE;
               end else if (kv) begin
                  n_st = ENTRY;
                  {n_min, n_tens, n_ones} = {sec_tens, sec_ones, key_digit};
               end
            end
         end
         RUN: begin
            if (stop || !door_closed) begin
               n_st = PAUSE;
            end else begin
               n_pre = tick ? '0 : pre + 1'b1;
               if (tick) begin
                  {n_min, n_tens, n_ones} = {dec_min, dec_tens, dec_ones};
                  n_st = dec_zero ? DONE : RUN;
               end
            end
         end
         PAUSE: begin
            if (stop) begin
               n_st = IDLE;
               {n_min, n_tens, n_ones} = 12'd0;
            end else if (start && door_closed) begin
               n_st = RUN;
            end
         end
         default: begin
            n_st = IDLE;
            {n_min, n_tens, n_ones} = 12'd0;
         end
      endcase
   end
   always_ff @(posedge clock) begin
      if (clear) begin
         st <= IDLE;
         pre <= '0;
         min <= 4'd0;
         sec_tens <= 4'd0;
         sec_ones <= 4'd0;
         running <= 1'b0;
         done <= 1'b0;
      end else begin
         st <= n_st;
         pre <= n_pre;
         min <= n_min;
         sec_tens <= n_tens;
         sec_ones <= n_ones;
         running <= n_st == RUN;
         done <= n_st == DONE;
      end
   end
   assign state = st;
endmodule

// File: tb/tb_timer_controller.sv
// tb_timer_controller: directed scoreboard bench for timer_controller with TICK_DIV=4
module tb_timer_controller;
   logic clock = 1'b0;
   logic clear, key_valid, start, stop, door_closed;
   logic [3:0] key_digit, min, sec_tens, sec_ones;
   logic running, done;
   logic [2:0] state;
   int n_tests = 0;
   int n_fail = 0;
   typedef struct {string tag; logic [16:0] v;} exp_t;
   exp_t q[$];
   localparam logic [2:0] S_IDLE = 3'd0, S_ENTRY = 3'd1, S_RUN = 3'd2, S_PAUSE = 3'd3, S_DONE = 3'd4;

   timer_controller #(.TICK_DIV(4)) dut (
      .clock(clock), .clear(clear), .key_valid(key_valid), .key_digit(key_digit),
      .start(start), .stop(stop), .door_closed(door_closed),
      .min(min), .sec_tens(sec_tens), .sec_ones(sec_ones),
      .running(running), .done(done), .state(state)
   );

   always #5 clock = ~clock;

   task automatic cyc(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic push(input string tag, input logic [2:0] s, input logic [3:0] m, input logic [3:0] t, input logic [3:0] o);
      exp_t e;
      e.tag = tag;
      e.v = {s, s == S_RUN, s == S_DONE, m, t, o};
      q.push_back(e);
   endtask

   task automatic drain();
      exp_t e;
      logic [16:0] obs;
      while (q.size() > 0) begin
         e = q.pop_front();
         obs = {state, running, done, min, sec_tens, sec_ones};
         n_tests++;
         assert (obs === e.v) else begin
            n_fail++;
            $error("FAIL %s: observed st=%0d run=%b done=%b %h:%h%h expected st=%0d run=%b done=%b %h:%h%h",
                   e.tag, obs[16:14], obs[13], obs[12], obs[11:8], obs[7:4], obs[3:0],
                   e.v[16:14], e.v[13], e.v[12], e.v[11:8], e.v[7:4], e.v[3:0]);
         end
      end
   endtask

   task automatic key(input logic [3:0] d);
      key_valid = 1'b1;
      key_digit = d;
      cyc(1);
      key_valid = 1'b0;
      key_digit = 4'd0;
   endtask

   task automatic press_start();
      start = 1'b1;
      cyc(1);
      start = 1'b0;
   endtask

   task automatic press_stop();
      stop = 1'b1;
      cyc(1);
      stop = 1'b0;
   endtask

   initial begin
      clear = 1'b1; key_valid = 1'b0; key_digit = 4'd0; start = 1'b0; stop = 1'b0; door_closed = 1'b1;
      cyc(2);
      clear = 1'b0;
      push("reset", S_IDLE, 0, 0, 0); drain();

      key(1); key(3); key(0);
      push("entry_130", S_ENTRY, 1, 3, 0); drain();
      press_start();
      push("start_130", S_RUN, 1, 3, 0); drain();
      cyc(4);
      push("first_dec", S_RUN, 1, 2, 9); drain();
      cyc(355);
      push("last_second", S_RUN, 0, 0, 1); drain();
      cyc(1);
      push("done_edge", S_DONE, 0, 0, 0); drain();
      start = 1'b1;
      cyc(1);
      push("done_start_idle", S_IDLE, 0, 0, 0);
      cyc(1);
      push("held_start_idle", S_IDLE, 0, 0, 0); drain();
      start = 1'b0;

      key(9); key(0);
      push("entry_090", S_ENTRY, 0, 9, 0); drain();
      press_start();
      push("norm_130", S_RUN, 1, 3, 0); drain();
      press_stop();
      push("run_stop_pause", S_PAUSE, 1, 3, 0); drain();
      press_stop();
      push("pause_stop_idle", S_IDLE, 0, 0, 0); drain();

      key(9); key(9); key(9);
      push("entry_999", S_ENTRY, 9, 9, 9); drain();
      press_start();
      push("clamp_959", S_RUN, 9, 5, 9); drain();
      press_stop(); press_stop();

      key(1); key(0);
      press_start();
      push("start_010", S_RUN, 0, 1, 0); drain();
      cyc(6);
      push("run_6cyc", S_RUN, 0, 0, 9); drain();
      door_closed = 1'b0;
      cyc(1);
      push("door_pause", S_PAUSE, 0, 0, 9); drain();
      start = 1'b1;
      cyc(3);
      push("pause_door_open_start", S_PAUSE, 0, 0, 9); drain();
      door_closed = 1'b1;
      cyc(1);
      start = 1'b0;
      push("resume", S_RUN, 0, 0, 9); drain();
      cyc(3);
      push("resume_3cyc", S_RUN, 0, 0, 9); drain();
      cyc(1);
      push("resume_4cyc", S_RUN, 0, 0, 8); drain();
      press_stop(); press_stop();

      key(1); key(2); key(3); key(4);
      push("shift_234", S_ENTRY, 2, 3, 4); drain();
      key(12);
      push("bad_key", S_ENTRY, 2, 3, 4); drain();
      press_stop();
      push("entry_stop", S_IDLE, 0, 0, 0); drain();
      press_start();
      push("idle_start", S_IDLE, 0, 0, 0); drain();
      key(0);
      press_start();
      push("start_zero_time", S_ENTRY, 0, 0, 0); drain();
      key(4);
      door_closed = 1'b0;
      press_start();
      push("start_door_open", S_ENTRY, 0, 0, 4); drain();
      door_closed = 1'b1;
      press_stop();

      key(1);
      press_start();
      push("start_001", S_RUN, 0, 0, 1); drain();
      cyc(3);
      stop = 1'b1;
      cyc(1);
      stop = 1'b0;
      push("stop_on_tick", S_PAUSE, 0, 0, 1); drain();
      press_start();
      push("resume_001", S_RUN, 0, 0, 1); drain();
      cyc(3);
      push("resume_001_3cyc", S_RUN, 0, 0, 1); drain();
      cyc(1);
      push("done_001", S_DONE, 0, 0, 0); drain();
      door_closed = 1'b0;
      cyc(1);
      push("done_door_open", S_DONE, 0, 0, 0); drain();
      door_closed = 1'b1;
      key(7);
      push("done_key", S_ENTRY, 0, 0, 7); drain();
      press_stop();

      key(5); key(2); key(7);
      press_start();
      push("start_527", S_RUN, 5, 2, 7); drain();
      cyc(2);
      clear = 1'b1; start = 1'b1; key_valid = 1'b1; key_digit = 4'd3;
      cyc(1);
      clear = 1'b0; start = 1'b0; key_valid = 1'b0; key_digit = 4'd0;
      push("clear_mid_run", S_IDLE, 0, 0, 0); drain();
      cyc(5);
      push("no_residual_tick", S_IDLE, 0, 0, 0); drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/timer_controller.md
# timer_controller

Sequencing controller for the Timer countdown datapath: collects keypad digits into an M:ST:SO time, normalises out-of-range seconds, and runs the three-digit BCD down-count at one step per second. It handles start, stop/pause and door interlock. It sits between keypad/door inputs and the display/magnetron outputs, replacing free-running control of the mod-6/mod-10 digit chain with one synchronous FSM.

## Interface
- TICK_DIV, 100_000_000: clock cycles per one-second countdown step (≥2); bench uses 4.
- clock  in  1  system clock, all logic on posedge.
- clear  in  1  synchronous, active-high reset.
- key_valid  in  1  one-cycle strobe, key_digit valid.
- key_digit  in  4  BCD digit 0–9; values 10–15 ignored.
- start  in  1  start/resume request, level sampled each cycle.
- stop  in  1  pause / cancel request.
- door_closed  in  1  high = door closed.
- min  out  4  minutes digit 0–9.
- sec_tens  out  4  seconds-tens digit (0–9 in ENTRY, 0–5 otherwise).
- sec_ones  out  4  seconds-ones digit 0–9.
- running  out  1  magnetron enable, high only in RUN.
- done  out  1  high only in DONE.
- state  out  3  IDLE=0, ENTRY=1, RUN=2, PAUSE=3, DONE=4.

## Operation
- Reset (clear=1 at posedge): state IDLE, min=sec_tens=sec_ones=0, prescaler=0, running=0, done=0. Clear overrides every other input.
- Input priority per cycle: clear > stop > door open (door_closed=0) > start > key_valid.
- Digit entry, IDLE/ENTRY/DONE, valid key (0–9): shift left. min←sec_tens, sec_tens←sec_ones, sec_ones←key_digit. Old min discarded. State→ENTRY.
- Invalid key_digit: no change.
- In RUN/PAUSE, key_valid ignored.
- IDLE: start ignored (time is 0:00).
- ENTRY, start with door_closed=1 and time≠0:00: normalise in the same cycle.
  - If sec_tens>5: sec_tens−=6, min+=1.
  - If min would become 10: load 9:59.
  - State→RUN, prescaler←0.
- ENTRY, start with door open or time=0:00: ignored.
- ENTRY, stop: time←0:00, state→IDLE.
- RUN, prescaler: counts 0..TICK_DIV−1; wrap produces a one-cycle tick.
- RUN, on tick: decrement as BCD.
  - sec_ones 0→9 with borrow from sec_tens.
  - sec_tens 0→5 with borrow from min.
  - If the result is 0:00, state→DONE in that same cycle.
- RUN, stop or door open: state→PAUSE. Time is held, prescaler←0. A tick in that cycle is discarded.
- PAUSE: start with door_closed=1 → RUN with prescaler←0. Stop → IDLE with time←0:00.
- DONE: time 0:00, done=1.
  - start or stop → IDLE.
  - Valid key → ENTRY with the digit shifted into 0:00.
  - Door open: no effect.
- Invalid state encodings → IDLE, time cleared.

## Timing
- All outputs registered; they change only at posedge clock.
- Key accepted at edge N is visible on the digit outputs after edge N.
- Start accepted at edge N: running=1 and normalised time visible after N.
- First decrement at edge N+TICK_DIV; subsequent decrements every TICK_DIV cycles.
- Total RUN duration for time T seconds: T·TICK_DIV cycles.
- The last decrement and the DONE transition occur at the same edge: running falls and done rises together.
- Stop/door-open at edge N: running=0 after N.
- Resume restarts a full TICK_DIV period; the partial second is lost.
- Clear during RUN: all outputs at reset values after that edge. No residual tick.
- Held start does not re-trigger from DONE: DONE→IDLE, then IDLE ignores start.

## Test plan
- Reset, keys 1,3,0, start (door closed), TICK_DIV=4 → 1:30 shown. Running=1. After 4 cycles 1:29. After 90·4 cycles total: 0:00, done=1, running=0, state=4.
- Keys 9,0, start → normalised to 1:30 at the start edge. Keys 9,9,9, start → 9:99 clamps to 9:59.
- Time 0:10, pause with door open after 6 cycles → 0:09 held, running=0. Door closed + start → running=1, next decrement exactly 4 cycles later gives 0:08.
- Keys 1,2,3,4 → display 2:34 (first digit dropped). Key_digit=12 → no change. Stop → 0:00, IDLE. Start in IDLE → stays IDLE.
- Same-cycle stop and tick in RUN at 0:01 → PAUSE at 0:01, done=0. Start → 0:00 and DONE after 4 cycles.
- Clear asserted mid-RUN at 5:27 → next edge IDLE, 0:00, running=0, done=0. Start and key asserted together with clear → ignored.
